// File: rtl/minirv_mem_pkg.sv
// -----------------------------------------------------------------------------
// minirv_mem_pkg
// Shared types and defaults for the MEM-stage bus bridge.
//   mem_state_t      : bridge FSM state encoding
//   WSEL_LOAD_DEF    : rf_wsel code that marks a load (lw)
//   TIMEOUT_DEF      : default REQ+WAIT cycle budget before abort
//   ERR_DATA_DEF     : load data returned on misalign/timeout
//   is_misaligned()  : true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package minirv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    localparam logic [1:0]  WSEL_LOAD_DEF = 2'b01;
    localparam int unsigned TIMEOUT_DEF   = 255;
    localparam logic [31:0] ERR_DATA_DEF  = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// -----------------------------------------------------------------------------
// bus_timeout_ctr
// Counts cycles spent with a bus transaction outstanding. Cleared when a new
// request is launched, advances on every enabled cycle, and flags expiry on
// the TIMEOUT-th enabled cycle so the owner can abort on that clock edge.
// Ports:
//   cpu_clk   in   clock, rising edge
//   cpu_rst_n in   asynchronous active-low reset
//   clear     in   restart the count at zero
//   enable    in   a transaction cycle is being spent
//   expire    out  this enabled cycle is the last one allowed
// -----------------------------------------------------------------------------
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic cpu_clk,
    input  logic cpu_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Holds at LAST: the owner leaves REQ/WAIT on expiry, so the count never
    // needs to run past the terminal value.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_bus_bridge.sv
// -----------------------------------------------------------------------------
// mem_bus_bridge
// Turns the load/store held in the MEM stage into one valid/ready bus
// transaction, stalls the pipeline until it completes and returns registered
// load data. Misaligned accesses and transactions that exceed the cycle
// budget complete immediately with ERR_DATA and set a sticky error flag.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | evaluate the MEM-stage instruction; launch, reject or ignore it
// REQ     | bus_req_valid high, request fields held until bus_req_ready
// WAIT    | request accepted, waiting for bus_resp_valid
// DONE    | result ready, stall released so the pipeline advances this edge
//
// Ports:
//   cpu_clk, cpu_rst_n   clock / async active-low reset
//   ram_we_MEM_in        store present in MEM
//   rf_wsel_MEM_in       load present when equal to WSEL_LOAD
//   ALU_C_MEM_in         byte address
//   rD2_MEM_in           store data
//   stall_mem            freeze IF..EX/MEM registers
//   rdata_MEM_out        load data, valid in DONE
//   bus_req_valid/ready  request handshake
//   bus_we, bus_addr,    request fields (word-aligned address)
//   bus_wdata
//   bus_resp_valid,      response / write acknowledge and read data
//   bus_rdata
//   bus_err              sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_bus_bridge
    import minirv_mem_pkg::*;
#(
    parameter logic [1:0]  WSEL_LOAD = WSEL_LOAD_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        ram_we_MEM_in,
    input  logic [1:0]  rf_wsel_MEM_in,
    input  logic [31:0] ALU_C_MEM_in,
    input  logic [31:0] rD2_MEM_in,
    output logic        stall_mem,
    output logic [31:0] rdata_MEM_out,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    mem_state_t state;

    logic is_store;
    logic is_load;
    logic mem_op;
    logic misaligned;
    logic ctr_clear;
    logic ctr_enable;
    logic ctr_expire;

    // A store wins when both flags are set.
    assign is_store   = ram_we_MEM_in;
    assign is_load    = (rf_wsel_MEM_in == WSEL_LOAD);
    assign mem_op     = is_store | is_load;
    assign misaligned = is_misaligned(ALU_C_MEM_in);

    assign stall_mem  = mem_op & (state != ST_DONE);

    assign ctr_clear  = (state == ST_IDLE) && mem_op && !misaligned;
    assign ctr_enable = (state == ST_REQ) || (state == ST_WAIT);

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .clear     (ctr_clear),
        .enable    (ctr_enable),
        .expire    (ctr_expire)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state         <= ST_IDLE;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            rdata_MEM_out <= '0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            bus_err       <= 1'b1;
                            rdata_MEM_out <= ERR_DATA;
                            state         <= ST_DONE;
                        end else begin
                            bus_addr      <= {ALU_C_MEM_in[31:2], 2'b00};
                            bus_we        <= is_store;
                            bus_wdata     <= rD2_MEM_in;
                            bus_req_valid <= 1'b1;
                            state         <= ST_REQ;
                        end
                    end
                end

                // Expiry beats a same-cycle ready: accepting would push the
                // transaction past its cycle budget.
                ST_REQ: begin
                    if (ctr_expire) begin
                        bus_req_valid <= 1'b0;
                        bus_err       <= 1'b1;
                        rdata_MEM_out <= ERR_DATA;
                        state         <= ST_DONE;
                    end else if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end

                // A response arriving in the last allowed cycle still counts
                // as a normal completion.
                ST_WAIT: begin
                    if (bus_resp_valid) begin
                        if (!bus_we) begin
                            rdata_MEM_out <= bus_rdata;
                        end
                        state <= ST_DONE;
                    end else if (ctr_expire) begin
                        bus_err       <= 1'b1;
                        rdata_MEM_out <= ERR_DATA;
                        state         <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_bridge
// Directed bench for mem_bus_bridge (TIMEOUT=4, ERR_DATA=0). A small bus
// responder inside do_op answers requests with a programmable ready delay and
// a one-cycle response right after acceptance.
// -----------------------------------------------------------------------------
module tb_mem_bus_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        ram_we_MEM_in = 1'b0;
    logic [1:0]  rf_wsel_MEM_in = 2'b00;
    logic [31:0] ALU_C_MEM_in = '0;
    logic [31:0] rD2_MEM_in = '0;
    logic        stall_mem;
    logic [31:0] rdata_MEM_out;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;

    always #5 cpu_clk = ~cpu_clk;

    mem_bus_bridge #(
        .WSEL_LOAD (2'b01),
        .TIMEOUT   (4),
        .ERR_DATA  (32'h0000_0000)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst_n      (cpu_rst_n),
        .ram_we_MEM_in  (ram_we_MEM_in),
        .rf_wsel_MEM_in (rf_wsel_MEM_in),
        .ALU_C_MEM_in   (ALU_C_MEM_in),
        .rD2_MEM_in     (rD2_MEM_in),
        .stall_mem      (stall_mem),
        .rdata_MEM_out  (rdata_MEM_out),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Accepted-request log, in order.
    int          hs_cnt = 0;
    logic [31:0] hs_addr [16];
    logic        hs_we   [16];

    always @(posedge cpu_clk) begin
        if (bus_req_valid && bus_req_ready && hs_cnt < 16) begin
            hs_addr[hs_cnt] <= bus_addr;
            hs_we[hs_cnt]   <= bus_we;
            hs_cnt          <= hs_cnt + 1;
        end
    end

    // Called at posedge+1 of the cycle in which the op is presented in MEM.
    // Returns at posedge+2 of the DONE cycle.
    task automatic do_op(input logic we, input logic [1:0] wsel,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int rdly, input logic [31:0] rsp,
                         output int stalls, output int reqc, output logic stable);
        logic        took;
        logic        acc;
        logic        done;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        w0;
        stalls = 0; reqc = 0; stable = 1'b1;
        acc = 1'b0; done = 1'b0; took = 1'b0;
        a0 = '0; d0 = '0; w0 = 1'b0;
        ram_we_MEM_in  = we;
        rf_wsel_MEM_in = wsel;
        ALU_C_MEM_in   = addr;
        rD2_MEM_in     = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (!stall_mem) begin
                done = 1'b1;
            end else begin
                stalls++;
                bus_req_ready  = 1'b0;
                bus_resp_valid = 1'b0;
                if (bus_req_valid) begin
                    reqc++;
                    if (reqc == 1) begin
                        a0 = bus_addr; d0 = bus_wdata; w0 = bus_we;
                    end else if (bus_addr !== a0 || bus_wdata !== d0 || bus_we !== w0) begin
                        stable = 1'b0;
                    end
                    bus_req_ready = (reqc > rdly);
                end else if (acc) begin
                    bus_resp_valid = 1'b1;
                    bus_rdata      = rsp;
                end
                took = bus_req_valid & bus_req_ready;
                @(posedge cpu_clk);
                #1;
                bus_req_ready  = 1'b0;
                bus_resp_valid = 1'b0;
                if (took) acc = 1'b1;
            end
        end
        check("op_completes", 32'(done), 32'd1);
    endtask

    // Advance past DONE into the following IDLE cycle with no op in MEM.
    task automatic next_idle();
        @(posedge cpu_clk);
        #1;
        ram_we_MEM_in  = 1'b0;
        rf_wsel_MEM_in = 2'b00;
    endtask

    int   st;
    int   rq;
    logic sb;
    int   hs0;

    initial begin
        // ---------------- reset values ----------------
        #2;
        check("rst_stall",  32'(stall_mem), 32'd0);
        check("rst_valid",  32'(bus_req_valid), 32'd0);
        check("rst_we",     32'(bus_we), 32'd0);
        check("rst_addr",   bus_addr, 32'h0);
        check("rst_wdata",  bus_wdata, 32'h0);
        check("rst_rdata",  rdata_MEM_out, 32'h0);
        check("rst_err",    32'(bus_err), 32'd0);
        rf_wsel_MEM_in = 2'b01;
        #1;
        check("rst_stall_follows_op", 32'(stall_mem), 32'd1);
        rf_wsel_MEM_in = 2'b00;
        @(posedge cpu_clk); @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk); #1;

        // ---------------- lw, zero-wait bus ----------------
        do_op(1'b0, 2'b01, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, st, rq, sb);
        check("lw_stalls", 32'(st), 32'd3);
        check("lw_reqs",   32'(rq), 32'd1);
        check("lw_rdata",  rdata_MEM_out, 32'h1234_5678);
        check("lw_we",     32'(bus_we), 32'd0);
        check("lw_addr",   bus_addr, 32'h0000_0010);
        check("lw_err",    32'(bus_err), 32'd0);
        next_idle();

        // ---------------- sw, ready delayed 2 ----------------
        do_op(1'b1, 2'b00, 32'h0000_0020, 32'hCAFE_F00D, 2, 32'hDEAD_BEEF, st, rq, sb);
        check("sw_stalls", 32'(st), 32'd5);
        check("sw_reqs",   32'(rq), 32'd3);
        check("sw_stable", 32'(sb), 32'd1);
        check("sw_we",     32'(bus_we), 32'd1);
        check("sw_addr",   bus_addr, 32'h0000_0020);
        check("sw_wdata",  bus_wdata, 32'hCAFE_F00D);
        check("sw_rdata_kept", rdata_MEM_out, 32'h1234_5678);
        check("sw_err",    32'(bus_err), 32'd0);
        next_idle();

        // ---------------- timeout: ready never comes ----------------
        do_op(1'b0, 2'b01, 32'h0000_0044, 32'h0, 100, 32'hBEEF_0000, st, rq, sb);
        check("to_stalls", 32'(st), 32'd5);
        check("to_reqs",   32'(rq), 32'd4);
        check("to_valid",  32'(bus_req_valid), 32'd0);
        check("to_rdata",  rdata_MEM_out, 32'h0);
        check("to_err",    32'(bus_err), 32'd1);
        next_idle();
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h55AA_55AA;
        @(posedge cpu_clk); #1;
        bus_resp_valid = 1'b0;
        check("to_late_resp_rdata", rdata_MEM_out, 32'h0);
        check("to_late_resp_valid", 32'(bus_req_valid), 32'd0);
        check("to_late_resp_stall", 32'(stall_mem), 32'd0);

        // ---------------- reset during WAIT ----------------
        rf_wsel_MEM_in = 2'b01;
        ALU_C_MEM_in   = 32'h0000_0050;
        @(posedge cpu_clk); #1;
        check("rw_req_valid", 32'(bus_req_valid), 32'd1);
        bus_req_ready = 1'b1;
        @(posedge cpu_clk); #1;
        bus_req_ready = 1'b0;
        check("rw_wait_stall", 32'(stall_mem), 32'd1);
        cpu_rst_n      = 1'b0;
        rf_wsel_MEM_in = 2'b00;
        #1;
        check("rw_valid", 32'(bus_req_valid), 32'd0);
        check("rw_addr",  bus_addr, 32'h0);
        check("rw_err",   32'(bus_err), 32'd0);
        check("rw_stall", 32'(stall_mem), 32'd0);
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk); #1;
        check("rw_post_stall", 32'(stall_mem), 32'd0);
        check("rw_post_valid", 32'(bus_req_valid), 32'd0);

        // ---------------- good load, then misaligned load ----------------
        do_op(1'b0, 2'b01, 32'h0000_0040, 32'h0, 0, 32'hA5A5_0001, st, rq, sb);
        check("lw2_stalls", 32'(st), 32'd3);
        check("lw2_rdata",  rdata_MEM_out, 32'hA5A5_0001);
        next_idle();
        do_op(1'b0, 2'b01, 32'h0000_0013, 32'h0, 0, 32'h0, st, rq, sb);
        check("mis_stalls", 32'(st), 32'd1);
        check("mis_reqs",   32'(rq), 32'd0);
        check("mis_rdata",  rdata_MEM_out, 32'h0);
        check("mis_err",    32'(bus_err), 32'd1);
        next_idle();

        // ---------------- back-to-back lw then sw ----------------
        hs0 = hs_cnt;
        do_op(1'b0, 2'b01, 32'h0000_0060, 32'h0, 0, 32'h1111_2222, st, rq, sb);
        check("b2b_lw_stalls", 32'(st), 32'd3);
        check("b2b_lw_rdata",  rdata_MEM_out, 32'h1111_2222);
        @(posedge cpu_clk); #1;
        do_op(1'b1, 2'b00, 32'h0000_0064, 32'h3333_4444, 0, 32'h0, st, rq, sb);
        check("b2b_sw_stalls", 32'(st), 32'd3);
        check("b2b_sw_wdata",  bus_wdata, 32'h3333_4444);
        check("b2b_rdata_kept", rdata_MEM_out, 32'h1111_2222);
        check("b2b_err_sticky", 32'(bus_err), 32'd1);
        check("b2b_hs_count",  32'(hs_cnt - hs0), 32'd2);
        check("b2b_hs0_addr",  hs_addr[hs0], 32'h0000_0060);
        check("b2b_hs0_we",    32'(hs_we[hs0]), 32'd0);
        check("b2b_hs1_addr",  hs_addr[hs0 + 1], 32'h0000_0064);
        check("b2b_hs1_we",    32'(hs_we[hs0 + 1]), 32'd1);
        next_idle();
        @(posedge cpu_clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

MEM-stage consumer of the EX/MEM pipeline register outputs. It turns each load or store sitting in the MEM stage into a valid/ready bus transaction toward the data RAM / peripheral bus. It stalls the pipeline until the transaction completes and delivers registered load data toward the MEM/WB register. It also detects misaligned and timed-out accesses.

## Interface
Parameters:
- WSEL_LOAD, 2'b01, rf_wsel code that marks a load (lw)
- TIMEOUT, 255, max cycles spent in REQ+WAIT before abort (1..65535)
- ERR_DATA, 32'h0, load data returned on misalign/timeout

Ports (one clock; reset is asynchronous and active-low):
- cpu_clk  in  1  clock, rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- ram_we_MEM_in  in  1  store present in MEM
- rf_wsel_MEM_in  in  2  load present when == WSEL_LOAD
- ALU_C_MEM_in  in  32  byte address
- rD2_MEM_in  in  32  store data
- stall_mem  out  1  freeze IF..EX/MEM registers
- rdata_MEM_out  out  32  load data, valid in DONE
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  write data
- bus_resp_valid  in  1  response/write-ack valid
- bus_rdata  in  32  read data
- bus_err  out  1  sticky error flag

## Operation
- mem_op = ram_we_MEM_in | (rf_wsel_MEM_in == WSEL_LOAD). ram_we has priority if both are set, and the op is treated as a store.
- stall_mem = mem_op & (state != DONE), combinational.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_op with ALU_C_MEM_in[1:0] != 0: go to DONE, set bus_err, rdata = ERR_DATA, no bus activity.
  - mem_op, aligned: latch bus_addr, bus_we, bus_wdata; go to REQ.
- REQ: bus_req_valid=1 and the request fields are held stable. On bus_req_ready, go to WAIT.
- WAIT: on bus_resp_valid, capture bus_rdata into rdata_MEM_out (loads only; stores leave it unchanged) and go to DONE. bus_resp_valid outside WAIT is ignored.
- Timeout counter: cleared on IDLE→REQ and increments every REQ/WAIT cycle. On reaching TIMEOUT:
  - go to DONE, set bus_err, rdata = ERR_DATA;
  - bus_req_valid drops; a late response is ignored.
- DONE: stall low, so the pipeline advances on this edge. Always go to IDLE next cycle; the following MEM instruction is evaluated in IDLE.
- bus_err is sticky and cleared only by reset.

## Timing
- Reset (async, immediate): state=IDLE, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_MEM_out=0, bus_err=0, counter=0. stall_mem then follows mem_op combinationally.
- Zero-wait bus (ready in the first REQ cycle, resp the cycle after acceptance):
  - stall high for 3 cycles (IDLE, REQ, WAIT);
  - DONE on the 4th cycle; rdata valid in DONE.
- Each extra ready or resp wait cycle adds one stall cycle.
- Misaligned access: 1 stall cycle, then DONE.
- Back-to-back memory ops: DONE→IDLE adds no extra bubble beyond the IDLE cycle of the next op.
- Reset asserted mid-REQ/WAIT: request abandoned, bus_req_valid low asynchronously. The responder must tolerate the abandoned transaction.

## Structure
- Package minirv_mem_pkg: state enum (IDLE/REQ/WAIT/DONE), WSEL_LOAD default, ERR_DATA default.
- One sub-module, bus_timeout_ctr: clear/enable/expire counter, width clog2(TIMEOUT+1).

## Test plan
- lw, addr 0x0000_0010, ready immediate, resp next cycle with rdata 0x1234_5678 → stall 3 cycles; DONE with rdata_MEM_out=0x1234_5678; bus_we=0.
- sw, addr 0x0000_0020, data 0xCAFE_F00D, ready delayed 2 cycles → bus fields stable for 3 REQ cycles; stall 5 cycles; bus_err=0.
- lw at addr 0x0000_0013 → no bus_req_valid; stall 1 cycle; rdata=ERR_DATA; bus_err=1, persisting through later good ops.
- TIMEOUT=4, lw, ready held low → abort after 4 REQ cycles; DONE; bus_err=1. A resp_valid injected afterward does not change rdata.
- lw immediately followed by sw → second op enters IDLE the cycle after DONE; two complete transactions in order; no lost or duplicated request.
- cpu_rst_n pulsed low during WAIT → all outputs 0 immediately; after release with no mem_op, stall_mem=0 and state=IDLE.
